// File: rtl/config_readback.sv
// Readback engine: snapshots the configuration vector on request and streams it
// as a framed byte sequence (header, length, payload, checksum) over valid/ready.
module config_readback #(
    parameter int unsigned CFG_WIDTH = 124,
    parameter logic [7:0]  HDR_BYTE  = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CFG_WIDTH-1:0] config_bit,
    output logic [7:0]           rb_data,
    output logic                 rb_valid,
    input  logic                 rb_ready,
    output logic                 rb_last,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned NBYTES   = (CFG_WIDTH + 7) / 8;
    localparam int unsigned SNAP_W   = NBYTES * 8;
    localparam logic [7:0]  LEN_BYTE = 8'(NBYTES);
    localparam logic [7:0]  LAST_IDX = 8'(NBYTES - 1);

    typedef enum logic [2:0] {IDLE, HDR, LEN, DATA, CSUM} state_t;

    state_t              state, state_next;
    logic [SNAP_W-1:0]   snap;
    logic [SNAP_W-1:0]   padded;
    logic [7:0]          idx;
    logic [7:0]          csum;
    logic [7:0]          cur_byte;

    // Bits above CFG_WIDTH in the last payload byte always read as zero.
    always_comb begin
        padded = '0;
        padded[CFG_WIDTH-1:0] = config_bit;
    end

    always_comb begin
        cur_byte = '0;
        for (int unsigned b = 0; b < NBYTES; b++) begin
            if (idx == 8'(b)) cur_byte = snap[b*8 +: 8];
        end
    end

    always_comb begin
        state_next = state;
        rb_valid   = 1'b0;
        rb_data    = '0;
        rb_last    = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) state_next = HDR;
            end
            HDR: begin
                rb_valid = 1'b1;
                rb_data  = HDR_BYTE;
                if (rb_ready) state_next = LEN;
            end
            LEN: begin
                rb_valid = 1'b1;
                rb_data  = LEN_BYTE;
                if (rb_ready) state_next = DATA;
            end
            DATA: begin
                rb_valid = 1'b1;
                rb_data  = cur_byte;
                if (rb_ready && idx == LAST_IDX) state_next = CSUM;
            end
            CSUM: begin
                rb_valid = 1'b1;
                rb_data  = csum;
                rb_last  = 1'b1;
                if (rb_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            snap  <= '0;
            idx   <= '0;
            csum  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == CSUM) && rb_ready;
            if (state == IDLE && start) begin
                snap <= padded;
                idx  <= '0;
                csum <= '0;
            end
            if (state == DATA && rb_ready) begin
                csum <= csum + cur_byte;
                idx  <= idx + 8'd1;
            end
        end
    end

endmodule
